// File: rtl/dt_pkg.sv
// rtl/dt_pkg.sv - shared constants and FSM state type for the distance-transform result scanner
package dt_pkg;
  localparam int IMG_W  = 128;
  localparam int IMG_H  = 128;
  localparam int PIX_W  = 8;
  localparam int ADDR_W = 14;
  localparam int CNT_W  = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/dt_scan_acc.sv
// rtl/dt_scan_acc.sv - running max / argmax / nonzero-count datapath for the result scan
module dt_scan_acc #(
  parameter int PIX_W = dt_pkg::PIX_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr_i,
  input  logic                      en_i,
  input  logic                      skip_i,
  input  logic [dt_pkg::ADDR_W-1:0] addr_i,
  input  logic [PIX_W-1:0]          data_i,
  output logic [PIX_W-1:0]          max_val_o,
  output logic [dt_pkg::ADDR_W-1:0] max_addr_o,
  output logic [dt_pkg::CNT_W-1:0]  fg_cnt_o
);
  import dt_pkg::*;

  logic [PIX_W-1:0]  max_val_q, max_val_d;
  logic [ADDR_W-1:0] max_addr_q, max_addr_d;
  logic [CNT_W-1:0]  fg_cnt_q, fg_cnt_d;

  always_comb begin
    max_val_d  = max_val_q;
    max_addr_d = max_addr_q;
    fg_cnt_d   = fg_cnt_q;
    if (clr_i) begin
      max_val_d  = '0;
      max_addr_d = '0;
      fg_cnt_d   = '0;
    end else if (en_i && !skip_i) begin
      // strict compare keeps the earliest (lowest) address on ties
      if (data_i > max_val_q) begin
        max_val_d  = data_i;
        max_addr_d = addr_i;
      end
      if (data_i != '0 && fg_cnt_q != '1) begin
        fg_cnt_d = fg_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      max_val_q  <= '0;
      max_addr_q <= '0;
      fg_cnt_q   <= '0;
    end else begin
      max_val_q  <= max_val_d;
      max_addr_q <= max_addr_d;
      fg_cnt_q   <= fg_cnt_d;
    end
  end

  assign max_val_o  = max_val_q;
  assign max_addr_o = max_addr_q;
  assign fg_cnt_o   = fg_cnt_q;
endmodule

// File: rtl/dt_scan.sv
// rtl/dt_scan.sv - scans the DT result RAM once per start, reporting max value, its address and foreground count
// Optional DT_SCAN_BORDER_SKIP_EN excludes the image border pixels from the statistics.
module dt_scan #(
  parameter int IMG_W = dt_pkg::IMG_W,
  parameter int IMG_H = dt_pkg::IMG_H,
  parameter int PIX_W = dt_pkg::PIX_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      res_rd,
  output logic [dt_pkg::ADDR_W-1:0] res_addr,
  input  logic [PIX_W-1:0]          res_di,
  output logic                      busy,
  output logic                      valid,
  output logic [PIX_W-1:0]          max_val,
  output logic [dt_pkg::ADDR_W-1:0] max_addr,
  output logic [dt_pkg::CNT_W-1:0]  fg_cnt
);
  import dt_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              acc_clr, acc_en, skip;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          addr_d  = '0;
          acc_clr = 1'b1;
        end
      end
      SCAN: begin
        acc_en = 1'b1;
        // address parks on the last pixel so it never wraps
        if (addr_q == LAST_ADDR) begin
          state_d = DONE;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

`ifdef DT_SCAN_BORDER_SKIP_EN
  logic [ADDR_W-1:0] row, col;
  assign col  = addr_q % ADDR_W'(IMG_W);
  assign row  = addr_q / ADDR_W'(IMG_W);
  assign skip = (row == '0) || (row == ADDR_W'(IMG_H - 1)) ||
                (col == '0) || (col == ADDR_W'(IMG_W - 1));
`else
  assign skip = 1'b0;
`endif

  dt_scan_acc #(.PIX_W(PIX_W)) u_acc (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (acc_clr),
    .en_i       (acc_en),
    .skip_i     (skip),
    .addr_i     (addr_q),
    .data_i     (res_di),
    .max_val_o  (max_val),
    .max_addr_o (max_addr),
    .fg_cnt_o   (fg_cnt)
  );

  assign res_rd   = (state_q == SCAN);
  assign res_addr = addr_q;
  assign busy     = (state_q != IDLE);
  assign valid    = (state_q == DONE);
endmodule

// File: tb/tb_dt_scan.sv
// tb/tb_dt_scan.sv - directed self-checking bench for dt_scan
`timescale 1ns/1ps
module tb_dt_scan;
  localparam int N = 16384;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di;
  logic        busy;
  logic        valid;
  logic [7:0]  max_val;
  logic [13:0] max_addr;
  logic [14:0] fg_cnt;

  logic [7:0] mem [0:N-1];
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign res_di = mem[res_addr];

  dt_scan dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .res_rd   (res_rd),
    .res_addr (res_addr),
    .res_di   (res_di),
    .busy     (busy),
    .valid    (valid),
    .max_val  (max_val),
    .max_addr (max_addr),
    .fg_cnt   (fg_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < N; i++) mem[i] = 8'h00;
  endtask

  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one full scan; returns the cycle of the valid pulse and an address-sequence flag.
  task automatic scan(input int repulse, output int vcyc, output bit seq_ok);
    kick();
    seq_ok = (res_addr == 14'd0) && res_rd && busy && !valid;
    vcyc = -1;
    for (int c = 1; c <= N + 200 && vcyc < 0; c++) begin
      start = (c == repulse);
      @(negedge clk);
      if (valid) begin
        vcyc = c;
        if (res_rd || res_addr != 14'(N - 1)) seq_ok = 1'b0;
      end else if (res_addr != 14'(c) || !res_rd || !busy) begin
        seq_ok = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_after(input string tag);
    @(negedge clk);
    chk({tag, "_valid_one_cycle"}, 32'(valid), 32'd0);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    chk({tag, "_rd_idle"}, 32'(res_rd), 32'd0);
    chk({tag, "_addr_hold"}, 32'(res_addr), 32'(N - 1));
  endtask

  initial begin
    int vcyc;
    bit seq_ok;
    bit no_valid;
    clear_mem();

    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rd", 32'(res_rd), 32'd0);
    chk("rst_addr", 32'(res_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_max_val", 32'(max_val), 32'd0);
    chk("rst_max_addr", 32'(max_addr), 32'd0);
    chk("rst_fg_cnt", 32'(fg_cnt), 32'd0);
    reset = 1'b0;

    // all-zero RAM with a start re-pulse at scan cycle 100
    scan(100, vcyc, seq_ok);
    chk("zero_valid_cycle", 32'(vcyc), 32'(N));
    chk("zero_addr_seq", 32'(seq_ok), 32'd1);
    chk("zero_max_val", 32'(max_val), 32'd0);
    chk("zero_max_addr", 32'(max_addr), 32'd0);
    chk("zero_fg_cnt", 32'(fg_cnt), 32'd0);
    check_after("zero");
    repeat (3) @(negedge clk);
    chk("zero_no_second_valid", 32'(valid | busy), 32'd0);

    // single value
    mem[14'h2081] = 8'h05;
    scan(0, vcyc, seq_ok);
    chk("single_valid_cycle", 32'(vcyc), 32'(N));
    chk("single_addr_seq", 32'(seq_ok), 32'd1);
    chk("single_max_val", 32'(max_val), 32'h05);
    chk("single_max_addr", 32'(max_addr), 32'h2081);
    chk("single_fg_cnt", 32'(fg_cnt), 32'd1);
    check_after("single");
    chk("single_hold_max_val", 32'(max_val), 32'h05);
    chk("single_hold_fg_cnt", 32'(fg_cnt), 32'd1);

    // tie keeps the lower address
    clear_mem();
    mem[300]  = 8'h40;
    mem[9000] = 8'h40;
    scan(0, vcyc, seq_ok);
    chk("tie_valid_cycle", 32'(vcyc), 32'(N));
    chk("tie_max_val", 32'(max_val), 32'h40);
    chk("tie_max_addr", 32'(max_addr), 32'd300);
    chk("tie_fg_cnt", 32'(fg_cnt), 32'd2);

    // reset in the middle of a scan over the border pattern
    clear_mem();
    mem[0]   = 8'h09;
    mem[129] = 8'h03;
    kick();
    no_valid = 1'b1;
    for (int c = 1; c < 5000; c++) begin
      @(negedge clk);
      if (valid) no_valid = 1'b0;
    end
    chk("abort_pre_busy", 32'(busy), 32'd1);
    chk("abort_pre_no_valid", 32'(no_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_rd", 32'(res_rd), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_addr", 32'(res_addr), 32'd0);
    chk("abort_max_val", 32'(max_val), 32'd0);
    chk("abort_fg_cnt", 32'(fg_cnt), 32'd0);
    repeat (2) @(negedge clk);
    chk("abort_stays_idle", 32'(valid | busy), 32'd0);

    scan(0, vcyc, seq_ok);
    chk("rescan_valid_cycle", 32'(vcyc), 32'(N));
    chk("rescan_addr_seq", 32'(seq_ok), 32'd1);
`ifdef DT_SCAN_BORDER_SKIP_EN
    chk("border_max_val", 32'(max_val), 32'd3);
    chk("border_max_addr", 32'(max_addr), 32'd129);
    chk("border_fg_cnt", 32'(fg_cnt), 32'd1);
`else
    chk("border_max_val", 32'(max_val), 32'd9);
    chk("border_max_addr", 32'(max_addr), 32'd0);
    chk("border_fg_cnt", 32'(fg_cnt), 32'd2);
`endif
    check_after("rescan");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
